irq_ctrl: RTL

//  Interrupt controller sitting directly downstream of the timer. It latches

---
 rtl/irq_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source edges into IF, masks them with IE, raises
// cpu_int/wake and runs the acknowledge handshake that returns the dispatch vector.
module irq_ctrl #(
    parameter int         NUM_IRQ     = 5,
    parameter logic [7:0] VECTOR_BASE = 8'h40
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               cpu_sel_if,
    input  logic               cpu_sel_ie,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_di,
    output logic [7:0]         cpu_do,
    output logic               cpu_int,
    output logic               wake,
    input  logic               cpu_int_ack,
    output logic [7:0]         cpu_vector
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [NUM_IRQ-1:0] if_r;
    logic [NUM_IRQ-1:0] if_nxt_s;
    logic [NUM_IRQ-1:0] req_prev_r;
    logic [7:0]         ie_r;
    logic [7:0]         vector_r;
    logic [NUM_IRQ-1:0] pend_s;
    logic [NUM_IRQ-1:0] set_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic [4:0]         pend_idx_s;
    logic               ack_take_s;
    logic               if_wr_s;
    logic               ie_wr_s;

    // Index of the lowest set bit; bit 0 wins arbitration.
    function automatic logic [4:0] lowest_idx(input logic [NUM_IRQ-1:0] p);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (p[i]) begin
                idx = i[4:0];
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] vector_of(input logic [4:0] n);
        return VECTOR_BASE + {n, 3'b000};
    endfunction

    assign pend_s     = ie_r[NUM_IRQ-1:0] & if_r;
    assign set_s      = irq_req & ~req_prev_r;
    assign pend_idx_s = lowest_idx(pend_s);
    assign ack_take_s = ce & cpu_int_ack & (state_r == ST_IDLE);
    assign if_wr_s    = ce & cpu_wr & cpu_sel_if;
    assign ie_wr_s    = ce & cpu_wr & cpu_sel_ie;
    assign wake       = |pend_s;
    assign cpu_int    = (state_r == ST_IDLE) & (|pend_s);
    assign cpu_vector = vector_r;
    assign cpu_do     = cpu_sel_if ? {{(8 - NUM_IRQ){1'b1}}, if_r} : ie_r;

    // Serviced-bit clear mask, only when a dispatch is actually taken.
    always_comb begin
        clr_s = {NUM_IRQ{1'b0}};
        if (ack_take_s && (|pend_s)) begin
            clr_s = {{(NUM_IRQ - 1){1'b0}}, 1'b1} << pend_idx_s;
        end else begin
            clr_s = {NUM_IRQ{1'b0}};
        end
    end

    // IF next value: a new edge beats an ack clear, which beats a CPU write.
    always_comb begin
        if_nxt_s = if_r;
        if (if_wr_s) begin
            if_nxt_s = cpu_di[NUM_IRQ-1:0];
        end else begin
            if_nxt_s = if_r;
        end
        if_nxt_s = (if_nxt_s & ~clr_s) | set_s;
    end

    // Acknowledge handshake next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ce && cpu_int_ack) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (ce && !cpu_int_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACK;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Register bank, all updates gated by the cpu clock enable.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            if_r       <= {NUM_IRQ{1'b0}};
            req_prev_r <= {NUM_IRQ{1'b0}};
            ie_r       <= 8'h00;
            vector_r   <= 8'h00;
        end else if (ce) begin
            state_r    <= state_nxt_s;
            if_r       <= if_nxt_s;
            req_prev_r <= irq_req;
            if (ie_wr_s) begin
                ie_r <= cpu_di;
            end
            if (ack_take_s) begin
                vector_r <= (|pend_s) ? vector_of(pend_idx_s) : 8'h00;
            end
        end
    end

endmodule
